fifo_rd_ctrl: RTL
=================

Name: fifo_rd_ctrl

Overview:
- Read-side controller for the team's 8-entry x 32-bit FIFO.
- Issues rd_en pops, captures the FIFO's registered d_out, and presents words downstream on a valid/ready stream.
- A 2-entry skid buffer absorbs the FIFO's 1-cycle read latency, so sustained throughput is 1 word/clk with no data loss.
- Sits between the FIFO and any 32-bit stream consumer.

Parameters:
- DW, 32, data width; must match FIFO d_out.
- CNTW, 16, width of the transferred-word counter (optional feature only).

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous discard of buffered and in-flight words.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  1  pop request to FIFO (combinational).
- fifo_rd_ack  input  1  FIFO read acknowledge; fifo_dout valid this cycle.
- fifo_dout  input  DW  FIFO read data (registered in FIFO).
- out_valid  output  1  downstream word valid.
- out_ready  input  1  downstream accept.
- out_data  output  DW  downstream word (head of skid buffer).
- busy  output  1  occupancy != 0 or read in flight.
- proto_err  output  1  sticky: ack received with no read in flight.
- xfer_cnt  output  CNTW  words delivered downstream (FIFO_RD_CNT_EN only).

Behaviour:
- Clock and reset: reset is reset_n, asynchronous, active-low; clock is clk. All state is flops with async clear on reset_n low.
- Reset values: occupancy 0, inflight 0, head 0, tail 0, out_valid 0, out_data 0, busy 0, proto_err 0, xfer_cnt 0.
- State machine (occupancy): S_EMPTY (0 words), S_ONE (1), S_TWO (2).
  - A write occurs on fifo_rd_ack with inflight=1.
  - A pop occurs on out_valid && out_ready.
  - Write only: EMPTY->ONE, ONE->TWO.
  - Pop only: TWO->ONE, ONE->EMPTY.
  - Write and pop in the same cycle: occupancy is unchanged.
- Skid buffer: 2 x DW regs. 1-bit tail advances on write, 1-bit head advances on pop, both wrap 1->0. out_data = buf[head]. out_valid = (state != S_EMPTY).
- Pop request: fifo_rd_en = !fifo_empty && !flush && (occ + inflight - pop) < 2, with pop = out_valid && out_ready.
  - This gives full throughput in steady state (occ=1, inflight=1, pop=1 -> rd_en=1).
- inflight flag:
  - Set the cycle after fifo_rd_en=1.
  - Cleared on fifo_rd_ack.
  - Same-cycle ack and new rd_en leaves it set.
- Read latency: rd_en at cycle N -> ack/data at N+1 -> out_valid at N+2 (if buffer was empty).
- Error handling: fifo_rd_ack while inflight=0 sets proto_err and is otherwise ignored (no write). proto_err clears only on reset.
- Stream rule: out_data is stable while out_valid=1 and out_ready=0. out_valid never deasserts without a pop or flush.
- Flush:
  - Next cycle: occupancy 0, head = tail = 0, out_valid 0.
  - If inflight=1 at flush, a drop flag is set. The next ack is discarded (no write, no proto_err), which clears the drop flag.
  - fifo_rd_en is 0 during the flush cycle.
  - A pop coinciding with flush still counts in xfer_cnt.
- busy = (occ != 0) || inflight || drop.
- Data ordering: strictly FIFO order; no word is duplicated or skipped.

Optional Feature:
- Macro FIFO_RD_CNT_EN.
- Defined: xfer_cnt (CNTW bits) increments by 1 on every pop and wraps at 2^CNTW-1 -> 0. Reset 0; flush does not clear it.
- Undefined: counter logic is absent and xfer_cnt is tied to 0.

Test Plan:
1. Reset mid-operation: FIFO holds 3 words, out_ready=0, assert reset_n=0 asynchronously -> all outputs 0 immediately; after release, rd_en reasserts and first word reappears unchanged.
2. Streaming: FIFO preloaded with 0x11111111..0x88888888, out_ready=1 -> rd_en high 8 consecutive cycles; out_data matches in order, one per clk from cycle 2; busy falls 2 cycles after last ack; xfer_cnt=8 (CNT_EN).
3. Backpressure: 4 words queued, out_ready=0 -> rd_en issued exactly twice, state S_TWO, out_data=word0 stable. Release out_ready -> words 0..3 in order, no loss.
4. Flush with read in flight: S_ONE, rd_en pulse, flush next cycle -> out_valid 0; following ack data 0xDEADBEEF never appears on out_data; proto_err stays 0.
5. Spurious ack: fifo_rd_ack=1 with inflight=0 -> proto_err=1 (sticky), occupancy unchanged; cleared only by reset_n.
6. Counter wrap (CNTW=4, CNT_EN): 17 pops -> xfer_cnt reads 15 then 0 then 1.

Source files
------------

// File: rtl/fifo_rd_ctrl_if.sv
// Handshake bundle between the FIFO read controller, the FIFO read port and the
// downstream valid/ready stream. master = controller view, slave = environment view.
interface fifo_rd_ctrl_if #(
   parameter int DW = 32
);
   logic          fifo_empty;
   logic          fifo_rd_en;
   logic          fifo_rd_ack;
   logic [DW-1:0] fifo_dout;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;

   modport master (
      input  fifo_empty,
      input  fifo_rd_ack,
      input  fifo_dout,
      input  out_ready,
      output fifo_rd_en,
      output out_valid,
      output out_data
   );

   modport slave (
      output fifo_empty,
      output fifo_rd_ack,
      output fifo_dout,
      output out_ready,
      input  fifo_rd_en,
      input  out_valid,
      input  out_data
   );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the 8x32 FIFO: pops words through a 2-entry skid buffer onto a
// valid/ready stream at 1 word/clk. Optional transferred-word counter under FIFO_RD_CNT_EN.
module fifo_rd_ctrl #(
   parameter int DW   = 32,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            flush,
   fifo_rd_ctrl_if.master  bus,
   output logic            busy,
   output logic            proto_err,
   output logic [CNTW-1:0] xfer_cnt
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   state_t        state_q;
   logic          vld_p1;
   logic [DW-1:0] skid_p1 [2];
   logic          head_q;
   logic          tail_q;
   logic          inflight_q;
   logic          drop_q;
   logic          proto_err_q;

   logic          pop;
   logic          ack_ok;
   logic          wr;
   logic          rd_req;
   logic [2:0]    load;

   assign pop    = vld_p1 && bus.out_ready;
   assign ack_ok = bus.fifo_rd_ack && inflight_q;
   assign wr     = ack_ok && !drop_q && !flush;

   // Words held plus words on their way, after this cycle's pop; a read is allowed while < 2.
   assign load   = {1'b0, state_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign rd_req = !bus.fifo_empty && !flush && (load < 3'd2);

   assign bus.fifo_rd_en = reset_n && rd_req;
   assign bus.out_valid  = vld_p1;
   assign bus.out_data   = skid_p1[head_q];
   assign busy           = (state_q != S_EMPTY) || inflight_q || drop_q;
   assign proto_err      = proto_err_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_EMPTY;
         vld_p1      <= 1'b0;
         skid_p1[0]  <= '0;
         skid_p1[1]  <= '0;
         head_q      <= 1'b0;
         tail_q      <= 1'b0;
         inflight_q  <= 1'b0;
         drop_q      <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         if (bus.fifo_rd_ack && !inflight_q) begin
            proto_err_q <= 1'b1;
         end

         if (rd_req) begin
            inflight_q <= 1'b1;
         end else if (bus.fifo_rd_ack) begin
            inflight_q <= 1'b0;
         end

         // A read still outstanding at flush time returns stale data; swallow that one ack.
         if (flush) begin
            drop_q <= inflight_q && !bus.fifo_rd_ack;
         end else if (ack_ok) begin
            drop_q <= 1'b0;
         end

         // ---- capture stage: FIFO d_out into skid entry ----
         if (wr) begin
            skid_p1[tail_q] <= bus.fifo_dout;
            tail_q          <= ~tail_q;
         end

         if (flush) begin
            state_q <= S_EMPTY;
            vld_p1  <= 1'b0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
         end else begin
            if (pop) begin
               head_q <= ~head_q;
            end
            case (state_q)
               S_EMPTY: begin
                  if (wr) begin
                     state_q <= S_ONE;
                     vld_p1  <= 1'b1;
                  end
               end
               S_ONE: begin
                  if (wr && !pop) begin
                     state_q <= S_TWO;
                  end else if (pop && !wr) begin
                     state_q <= S_EMPTY;
                     vld_p1  <= 1'b0;
                  end
               end
               S_TWO: begin
                  if (pop && !wr) begin
                     state_q <= S_ONE;
                  end
               end
               default: begin
                  state_q <= S_EMPTY;
                  vld_p1  <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef FIFO_RD_CNT_EN
   logic [CNTW-1:0] cnt_q;

   // Counts every delivered word, including a pop that lands in a flush cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (pop) begin
         cnt_q <= cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
      end
   end

   assign xfer_cnt = cnt_q;
`else
   assign xfer_cnt = '0;
`endif

endmodule
